// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - RV32I program counter with fetch handshake, redirects, misalign and trap entry
module pc_fetch_unit #(
    parameter int unsigned      dataW        = 32,
    parameter logic [dataW-1:0] ResetVector  = '0,
    parameter logic [dataW-1:0] TrapVector   = dataW'(32'h100),
    parameter bit               CompressedEn = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EQ,
    input  logic             NE,
    input  logic             LT,
    input  logic             LTU,
    input  logic             GE,
    input  logic             GEU,
    input  logic             BranchControl,
    input  logic [2:0]       PCBranchType,
    input  logic [1:0]       JumpMode,
    input  logic [dataW-1:0] BranchOffset,
    input  logic [dataW-1:0] RegBase,
    input  logic             InstrLen,
    input  logic             Stall,
    input  logic             FetchReady,
    input  logic             TrapReq,
    output logic [dataW-1:0] ProgAddr,
    output logic             FetchValid,
    output logic [dataW-1:0] LinkAddr,
    output logic [dataW-1:0] EPC,
    output logic             Misaligned
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    localparam logic [1:0] JM_SEQ  = 2'b00;
    localparam logic [1:0] JM_JAL  = 2'b01;
    localparam logic [1:0] JM_JALR = 2'b10;
    localparam logic [1:0] JM_MRET = 2'b11;

    state_e           state_q, state_d;
    logic [dataW-1:0] pc_q, pc_d;
    logic [dataW-1:0] epc_q, epc_d;
    logic             mis_q, mis_d;

    logic [dataW-1:0] step;
    logic [dataW-1:0] jalr_sum;
    logic [dataW-1:0] target;
    logic [5:0]       flags;
    logic             cond_taken;
    logic             redirect;
    logic             target_bad;
    logic             adv;

    // 16-bit step only exists when compressed support is built in
    always_comb begin
        step = dataW'(4);
        if (CompressedEn && !InstrLen) begin
            step = dataW'(2);
        end
    end

    always_comb begin
        flags      = {GEU, GE, LTU, LT, NE, EQ};
        cond_taken = 1'b0;
        if (BranchControl && (PCBranchType <= 3'd5)) begin
            cond_taken = flags[PCBranchType];
        end
    end

    always_comb begin
        jalr_sum = RegBase + BranchOffset;
        redirect = 1'b1;
        target   = pc_q + step;
        case (JumpMode)
            JM_MRET: target = epc_q;
            JM_JALR: target = jalr_sum & ~dataW'(1);
            JM_JAL:  target = pc_q + BranchOffset;
            default: begin
                if (cond_taken) begin
                    target = pc_q + BranchOffset;
                end else begin
                    redirect = 1'b0;
                end
            end
        endcase
        // sequential steps are aligned by construction; only redirects are checked
        target_bad = redirect && (target[0] || (!CompressedEn && target[1]));
    end

    assign adv = FetchReady && !Stall;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_TRAP: state_d = ST_RUN;
            ST_RUN: begin
                if (TrapReq) begin
                    epc_d   = pc_q;
                    pc_d    = TrapVector;
                    state_d = ST_TRAP;
                end else if (adv) begin
                    if (target_bad) begin
                        mis_d   = 1'b1;
                        epc_d   = pc_q;
                        pc_d    = TrapVector;
                        state_d = ST_TRAP;
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= ResetVector;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign ProgAddr   = pc_q;
    assign FetchValid = (state_q == ST_RUN);
    assign LinkAddr   = pc_q + step;
    assign EPC        = epc_q;
    assign Misaligned = mis_q;

    // JM_SEQ is the default arm of the target select
    logic unused_jm;
    assign unused_jm = (JumpMode == JM_SEQ);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized and directed checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h80;
    localparam logic [31:0] TV = 32'h100;

    logic        clock = 1'b0;
    logic        reset;
    logic        EQ, NE, LT, LTU, GE, GEU;
    logic        BranchControl;
    logic [2:0]  PCBranchType;
    logic [1:0]  JumpMode;
    logic [31:0] BranchOffset;
    logic [31:0] RegBase;
    logic        InstrLen;
    logic        Stall;
    logic        FetchReady;
    logic        TrapReq;

    logic [31:0] prog_addr [2];
    logic        fetch_valid [2];
    logic [31:0] link_addr [2];
    logic [31:0] epc [2];
    logic        misaligned [2];

    int pass_cnt  = 0;
    int total_cnt = 0;

    pc_fetch_unit #(.dataW(32), .ResetVector(RV), .TrapVector(TV), .CompressedEn(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
        .BranchControl(BranchControl), .PCBranchType(PCBranchType), .JumpMode(JumpMode),
        .BranchOffset(BranchOffset), .RegBase(RegBase), .InstrLen(InstrLen),
        .Stall(Stall), .FetchReady(FetchReady), .TrapReq(TrapReq),
        .ProgAddr(prog_addr[0]), .FetchValid(fetch_valid[0]), .LinkAddr(link_addr[0]),
        .EPC(epc[0]), .Misaligned(misaligned[0])
    );

    pc_fetch_unit #(.dataW(32), .ResetVector(RV), .TrapVector(TV), .CompressedEn(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
        .BranchControl(BranchControl), .PCBranchType(PCBranchType), .JumpMode(JumpMode),
        .BranchOffset(BranchOffset), .RegBase(RegBase), .InstrLen(InstrLen),
        .Stall(Stall), .FetchReady(FetchReady), .TrapReq(TrapReq),
        .ProgAddr(prog_addr[1]), .FetchValid(fetch_valid[1]), .LinkAddr(link_addr[1]),
        .EPC(epc[1]), .Misaligned(misaligned[1])
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model phases: 0 = boot, 1 = running, 2 = trap bubble
    logic [31:0] m_pc [2];
    logic [31:0] m_epc [2];
    int          m_ph [2];
    bit          m_mis [2];

    function automatic logic [31:0] model_step(input int i);
        return (i == 1 && !InstrLen) ? 32'd2 : 32'd4;
    endfunction

    always @(posedge clock) begin
        logic [31:0] tgt;
        logic [5:0]  fl;
        bit          redir, bad;
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_pc[i] = RV; m_epc[i] = 32'h0; m_ph[i] = 0; m_mis[i] = 1'b0;
            end else begin
                m_mis[i] = 1'b0;
                if (m_ph[i] != 1) begin
                    m_ph[i] = 1;
                end else if (TrapReq) begin
                    m_epc[i] = m_pc[i]; m_pc[i] = TV; m_ph[i] = 2;
                end else if (FetchReady && !Stall) begin
                    fl    = {GEU, GE, LTU, LT, NE, EQ};
                    redir = 1'b1;
                    case (JumpMode)
                        2'd3:    tgt = m_epc[i];
                        2'd2:    tgt = (RegBase + BranchOffset) & 32'hFFFF_FFFE;
                        2'd1:    tgt = m_pc[i] + BranchOffset;
                        default: begin
                            if (BranchControl && PCBranchType < 6 && fl[PCBranchType]) tgt = m_pc[i] + BranchOffset;
                            else begin tgt = m_pc[i] + model_step(i); redir = 1'b0; end
                        end
                    endcase
                    bad = redir && (tgt[0] || (i == 0 && tgt[1]));
                    if (bad) begin
                        m_mis[i] = 1'b1; m_epc[i] = m_pc[i]; m_pc[i] = TV; m_ph[i] = 2;
                    end else begin
                        m_pc[i] = tgt;
                    end
                end
            end
        end
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("ProgAddr[%0d]", i), prog_addr[i], m_pc[i]);
            check($sformatf("FetchValid[%0d]", i), 32'(fetch_valid[i]), 32'(m_ph[i] == 1));
            check($sformatf("EPC[%0d]", i), epc[i], m_epc[i]);
            check($sformatf("Misaligned[%0d]", i), 32'(misaligned[i]), 32'(m_mis[i]));
            check($sformatf("LinkAddr[%0d]", i), link_addr[i], m_pc[i] + model_step(i));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #3;
    endtask

    task automatic idle_inputs();
        {EQ, NE, LT, LTU, GE, GEU} = 6'b0;
        BranchControl = 1'b0; PCBranchType = 3'd0; JumpMode = 2'd0;
        BranchOffset = 32'h0; RegBase = 32'h0; InstrLen = 1'b1;
        Stall = 1'b0; FetchReady = 1'b1; TrapReq = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] from, input logic [31:0] to);
        JumpMode = 2'd1; BranchOffset = to - from;
        cyc();
        JumpMode = 2'd0; BranchOffset = 32'h0;
        check("jal_to", prog_addr[0], to);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        cyc();
        check("rst_pc", prog_addr[0], 32'h80);
        check("rst_fv", 32'(fetch_valid[0]), 32'h0);
        check("rst_epc", epc[0], 32'h0);
        check("rst_link", link_addr[0], 32'h84);
        reset = 1'b1;
        cyc();
        check("boot_pc", prog_addr[0], 32'h80);
        check("run_fv", 32'(fetch_valid[0]), 32'h1);
        cyc();
        check("seq_pc", prog_addr[0], 32'h84);

        jump_to(32'h84, 32'h10);
        Stall = 1'b1;
        repeat (3) begin cyc(); check("stall_hold", prog_addr[0], 32'h10); end
        Stall = 1'b0; FetchReady = 1'b0;
        repeat (3) begin cyc(); check("ready_hold", prog_addr[0], 32'h10); end
        FetchReady = 1'b1;
        cyc();
        check("release", prog_addr[0], 32'h14);

        jump_to(32'h14, 32'h40);
        BranchControl = 1'b1; PCBranchType = 3'd2; LT = 1'b1; BranchOffset = 32'hFFFF_FFF8;
        cyc();
        check("br_taken", prog_addr[0], 32'h38);
        BranchControl = 1'b0; LT = 1'b0;
        jump_to(32'h38, 32'h40);
        BranchControl = 1'b1; PCBranchType = 3'd2; LT = 1'b0; BranchOffset = 32'hFFFF_FFF8;
        cyc();
        check("br_not_taken", prog_addr[0], 32'h44);
        BranchControl = 1'b0;
        jump_to(32'h44, 32'h40);
        BranchControl = 1'b1; PCBranchType = 3'd7; {EQ, NE, LT, LTU, GE, GEU} = 6'h3F;
        BranchOffset = 32'hFFFF_FFF8;
        cyc();
        check("br_type7", prog_addr[0], 32'h44);
        idle_inputs();

        check("link_pre_jalr", link_addr[0], 32'h48);
        JumpMode = 2'd2; RegBase = 32'h1001; BranchOffset = 32'h4;
        cyc();
        check("jalr", prog_addr[0], 32'h1004);
        idle_inputs();

        jump_to(32'h1004, 32'h20);
        JumpMode = 2'd1; BranchOffset = 32'h6;
        cyc();
        check("mis_pulse", 32'(misaligned[0]), 32'h1);
        check("mis_epc", epc[0], 32'h20);
        check("mis_pc", prog_addr[0], 32'h100);
        check("mis_bubble", 32'(fetch_valid[0]), 32'h0);
        check("c_mis_none", 32'(misaligned[1]), 32'h0);
        check("c_jal_odd2", prog_addr[1], 32'h26);
        idle_inputs();
        cyc();
        check("mis_clear", 32'(misaligned[0]), 32'h0);
        check("mis_resume", 32'(fetch_valid[0]), 32'h1);

        jump_to(32'h100, 32'h54);
        Stall = 1'b1; TrapReq = 1'b1;
        cyc();
        check("trap_epc", epc[0], 32'h54);
        check("trap_pc", prog_addr[0], 32'h100);
        idle_inputs();
        cyc();
        cyc();
        check("trap_seq", prog_addr[0], 32'h104);
        JumpMode = 2'd3;
        cyc();
        check("mret", prog_addr[0], 32'h54);
        idle_inputs();

        jump_to(32'h54, 32'hFFFF_FFFC);
        cyc();
        check("wrap", prog_addr[0], 32'h0);

        reset = 1'b0;
        #1;
        check("async_rst_pc", prog_addr[0], 32'h80);
        check("async_rst_fv", 32'(fetch_valid[0]), 32'h0);
        check("async_rst_epc", epc[0], 32'h0);
        cyc();
        reset = 1'b1;
        cyc();

        for (int n = 0; n < 4000; n++) begin
            reset         = ($urandom_range(0, 199) != 0);
            {EQ, NE, LT, LTU, GE, GEU} = 6'($urandom);
            BranchControl = $urandom_range(0, 1) == 1;
            PCBranchType  = 3'($urandom_range(0, 7));
            JumpMode      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            BranchOffset  = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 63)) - 32)
                                                        : 32'(int'($urandom_range(0, 31)) * 4 - 64);
            RegBase       = 32'($urandom_range(0, 32'h3FF));
            InstrLen      = $urandom_range(0, 1) == 1;
            Stall         = $urandom_range(0, 3) == 0;
            FetchReady    = $urandom_range(0, 3) != 0;
            TrapReq       = $urandom_range(0, 19) == 0;
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
